wr_decode_scoreboard: RTL and testbench

Parametrised write-port decoder and pending-write scoreboard for the register file of the pipelined CPU. It turns the write-back register number into a one-hot write enable for the register file. It also tracks how many in-flight instructions will write each register, so decode can raise a RAW hazard stall. It sits between the decode/issue stage and the register file, and is driven by issue (ID) and write-back (WB) controls.

---
 rtl/cpu_regs_pkg.sv | 10 +
 rtl/onehot_decode.sv | 15 +
 rtl/wr_decode_scoreboard.sv | 97 +++++++++
 tb/tb_wr_decode_scoreboard.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_regs_pkg.sv
// Shared register-file definitions for the CPU.
// Default register-number width, zero register and register-number type.
package cpu_regs_pkg;

    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] regnum_t;

endpackage

// File: rtl/onehot_decode.sv
// Generic enable-gated binary to one-hot decoder.
module onehot_decode #(
    parameter int ADDR_W = 5
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      sel,
    output logic [2**ADDR_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/wr_decode_scoreboard.sv
// Register-file write decoder plus per-register pending-write counters
// used by decode to detect RAW hazards and throttle issue.
module wr_decode_scoreboard
    import cpu_regs_pkg::*;
#(
    parameter int ADDR_W   = cpu_regs_pkg::ADDR_W,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = cpu_regs_pkg::ZERO_REG,
    parameter int HAS_ZERO = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_rd,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_rd,
    input  logic [ADDR_W-1:0]      rs_a,
    input  logic [ADDR_W-1:0]      rs_b,
    output logic [2**ADDR_W-1:0]   reg_we,
    output logic [2**ADDR_W-1:0]   busy,
    output logic                   hazard_a,
    output logic                   hazard_b,
    output logic                   stall,
    output logic                   issue_block,
    output logic                   err_ovf,
    output logic                   err_unf
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [NREG-1:0] ONE = NREG'(1);
    localparam logic [NREG-1:0] ZMASK =
        (HAS_ZERO != 0) ? ~(ONE << ZERO_REG) : '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0] wb_raw;
    logic [NREG-1:0] is_raw;
    logic [NREG-1:0] is_oh;
    logic [NREG-1:0] sat;
    logic [NREG-1:0] empty;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic            unf_hit;

    onehot_decode #(.ADDR_W(ADDR_W)) u_wb_dec (
        .en     (wb_valid & ~reset),
        .sel    (wb_rd),
        .onehot (wb_raw)
    );

    onehot_decode #(.ADDR_W(ADDR_W)) u_is_dec (
        .en     (issue_valid & ~reset),
        .sel    (issue_rd),
        .onehot (is_raw)
    );

    assign reg_we = wb_raw & ZMASK;
    assign is_oh  = is_raw & ZMASK;
    assign dec    = reg_we;

    always_comb begin
        sat   = '0;
        empty = '0;
        for (int r = 0; r < NREG; r++) begin
            sat[r]   = (cnt[r] == CMAX);
            empty[r] = (cnt[r] == '0);
        end
    end

    // A same-cycle write-back frees the slot, so a saturated issue may proceed
    assign inc         = is_oh & (~sat | dec);
    assign issue_block = |(is_oh & sat & ~dec);
    assign unf_hit     = |(dec & ~inc & empty);

    assign busy     = ~empty;
    assign hazard_a = busy[rs_a];
    assign hazard_b = busy[rs_b];
    assign stall    = hazard_a | hazard_b | issue_block;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc[r] && !dec[r])
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec[r] && !inc[r] && !empty[r])
                    cnt[r] <= cnt[r] - 1'b1;
            end
            if (issue_block) err_ovf <= 1'b1;
            if (unf_hit)     err_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wr_decode_scoreboard.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_wr_decode_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [4:0]  rs_a;
    logic [4:0]  rs_b;

    logic [31:0] reg_we, busy;
    logic        hazard_a, hazard_b, stall, issue_block, err_ovf, err_unf;
    logic [31:0] nz_reg_we, nz_busy;
    logic        nz_hazard_a, nz_hazard_b, nz_stall, nz_issue_block;
    logic        nz_err_ovf, nz_err_unf;

    wr_decode_scoreboard #(
        .ADDR_W(5), .CNT_W(2), .ZERO_REG(31), .HAS_ZERO(1)
    ) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rs_a(rs_a), .rs_b(rs_b),
        .reg_we(reg_we), .busy(busy),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .stall(stall), .issue_block(issue_block),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    wr_decode_scoreboard #(
        .ADDR_W(5), .CNT_W(2), .ZERO_REG(31), .HAS_ZERO(0)
    ) dut_nz (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rs_a(rs_a), .rs_b(rs_b),
        .reg_we(nz_reg_we), .busy(nz_busy),
        .hazard_a(nz_hazard_a), .hazard_b(nz_hazard_b),
        .stall(nz_stall), .issue_block(nz_issue_block),
        .err_ovf(nz_err_ovf), .err_unf(nz_err_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       name;
    } exp_t;

    localparam int F_WE  = 0;
    localparam int F_BSY = 1;
    localparam int F_HA  = 2;
    localparam int F_HB  = 3;
    localparam int F_STL = 4;
    localparam int F_BLK = 5;
    localparam int F_OVF = 6;
    localparam int F_UNF = 7;
    localparam int F_NHB = 8;
    localparam int F_NWE = 9;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int fld);
        case (fld)
            F_WE:    return reg_we;
            F_BSY:   return busy;
            F_HA:    return {31'd0, hazard_a};
            F_HB:    return {31'd0, hazard_b};
            F_STL:   return {31'd0, stall};
            F_BLK:   return {31'd0, issue_block};
            F_OVF:   return {31'd0, err_ovf};
            F_UNF:   return {31'd0, err_unf};
            F_NHB:   return {31'd0, nz_hazard_b};
            F_NWE:   return nz_reg_we;
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: every negedge, pop and compare expectations due this cycle
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                act = actual(sbq[i].fld);
                checks++;
                if (act !== sbq[i].val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h want %h",
                             sbq[i].name, cyc, act, sbq[i].val);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic want(input int dc, input int fld,
                        input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.fld  = fld;
        e.val  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
    endtask

    task automatic iss(input logic [4:0] r);
        issue_valid = 1'b1;
        issue_rd    = r;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc %0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; rs_a = '0; rs_b = '0;

        // reset cycle: inputs present but must be ignored
        tick(); reset = 1'b1; wb(3); iss(4);
        want(0, F_WE,  32'h0, "we_in_reset");
        want(0, F_BLK, 32'h0, "blk_in_reset");

        tick(); wb(3);
        want(0, F_BSY, 32'h0, "busy_after_reset");
        want(0, F_OVF, 32'h0, "ovf_after_reset");
        want(0, F_UNF, 32'h0, "unf_after_reset");
        want(0, F_STL, 32'h0, "stall_after_reset");
        want(0, F_WE,  32'h0000_0008, "we_rd3");
        want(1, F_UNF, 32'h1, "unf_set");

        tick(); wb(31);
        want(0, F_WE,  32'h0, "we_zero_reg");
        want(0, F_NWE, 32'h8000_0000, "nz_we_rd31");
        want(1, F_UNF, 32'h1, "unf_sticky");

        tick(); iss(5); rs_a = 5;
        want(0, F_HA,  32'h0, "haz_a_same_cyc");
        want(1, F_HA,  32'h1, "haz_a_next");
        want(1, F_BSY, 32'h0000_0020, "busy5");

        tick();
        tick(); wb(5);
        want(0, F_WE,  32'h0000_0020, "we_rd5");
        want(0, F_HA,  32'h1, "haz_a_during_wb");
        want(1, F_HA,  32'h0, "haz_a_cleared");
        want(1, F_BSY, 32'h0, "busy5_cleared");

        tick(); iss(7); rs_a = 7;
        tick(); iss(7);
        tick(); iss(7);
        tick(); iss(7);
        want(0, F_BLK, 32'h1, "blk_sat7");
        want(0, F_STL, 32'h1, "stall_sat7");
        want(0, F_OVF, 32'h0, "ovf_not_yet");
        want(1, F_OVF, 32'h1, "ovf_set");
        want(1, F_BSY, 32'h0000_0080, "busy7");

        tick(); iss(7); wb(7); rs_a = 0;
        want(0, F_BLK, 32'h0, "blk_freed_by_wb");
        want(0, F_STL, 32'h0, "stall_freed_by_wb");
        want(0, F_WE,  32'h0000_0080, "we_rd7");

        tick(); iss(7);
        want(0, F_BLK, 32'h1, "blk_cnt7_still3");

        tick(); wb(7);
        tick(); wb(7);
        tick(); wb(7);
        want(0, F_BSY, 32'h0000_0080, "busy7_cnt1");
        want(1, F_BSY, 32'h0, "busy7_drained");

        tick(); iss(9);
        tick(); iss(10);
        tick(); iss(9); wb(9);
        want(0, F_BLK, 32'h0, "blk_inc_dec9");
        want(1, F_BSY, 32'h0000_0600, "busy9_10");

        tick(); iss(9); wb(10);
        want(1, F_BSY, 32'h0000_0200, "busy10_dec");

        tick(); wb(9);
        want(1, F_BSY, 32'h0000_0200, "busy9_cnt1");

        tick(); wb(9);
        want(1, F_BSY, 32'h0, "busy9_drained");

        tick(); iss(31); rs_b = 31;
        want(0, F_BLK, 32'h0, "blk_zero_reg");
        want(1, F_BSY, 32'h0, "busy_zero_reg");
        want(1, F_HB,  32'h0, "haz_b_zero_reg");
        want(1, F_NHB, 32'h1, "nz_haz_b_rd31");

        tick();
        want(1, F_HB,  32'h0, "haz_b_zero_later");
        want(1, F_OVF, 32'h1, "ovf_sticky");
        want(1, F_UNF, 32'h1, "unf_sticky2");

        tick(); iss(12);
        tick(); iss(13); rs_a = 12; rs_b = 13;
        tick(); reset = 1'b1; iss(14); wb(12);
        want(0, F_BSY, 32'h0000_3000, "busy12_13");
        want(0, F_HA,  32'h1, "haz_a12");
        want(0, F_HB,  32'h1, "haz_b13");
        want(0, F_WE,  32'h0, "we_mid_reset");
        want(1, F_BSY, 32'h0, "busy_flushed");
        want(1, F_OVF, 32'h0, "ovf_cleared");
        want(1, F_UNF, 32'h0, "unf_cleared");
        want(1, F_STL, 32'h0, "stall_cleared");
        want(1, F_HA,  32'h0, "haz_a_cleared_rst");
        want(1, F_HB,  32'h0, "haz_b_cleared_rst");

        tick();
        tick();
        tick();
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL unconsumed got %0d want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
